// File: rtl/ad79x8_pkg.sv
// Shared constants, FSM state type and control-word builder for the AD79x8 scan controller.
package ad79x8_pkg;

    localparam int FRAME_BITS   = 16;
    localparam int FRAME_HALVES = 2 * FRAME_BITS;

    // Control register bit positions (DIN, MSB first)
    localparam int CTRL_WRITE   = 15;
    localparam int CTRL_SEQ     = 14;
    localparam int CTRL_ADD_LSB = 10;
    localparam int CTRL_PM_LSB  = 8;
    localparam int CTRL_SHADOW  = 7;
    localparam int CTRL_RANGE   = 5;
    localparam int CTRL_CODING  = 4;

    // DOUT layout: leading zero, ADD2..0, then 12 data bits
    localparam int DOUT_ADD_LSB  = 12;
    localparam int DOUT_DATA_MSB = 11;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    function automatic logic [FRAME_BITS-1:0] build_ctrl(
        input logic [2:0] ch,
        input logic [1:0] pm,
        input logic       rng,
        input logic       coding
    );
        logic [FRAME_BITS-1:0] w;
        w                   = '0;
        w[CTRL_WRITE]       = 1'b1;
        w[CTRL_SEQ]         = 1'b0;
        w[CTRL_ADD_LSB +: 3] = ch;
        w[CTRL_PM_LSB +: 2] = pm;
        w[CTRL_SHADOW]      = 1'b0;
        w[CTRL_RANGE]       = rng;
        w[CTRL_CODING]      = coding;
        return w;
    endfunction

endpackage

// File: rtl/ad79x8_sclk_gen.sv
// Half-period timer for one frame: half 0 is the SETUP interval, halves 1..32 alternate sclk low/high.
module ad79x8_sclk_gen
    import ad79x8_pkg::*;
#(
    parameter int CLK_DIV = 2
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  logic       i_en_next,
    output logic       o_sclk,
    output logic       o_half_end,
    output logic       o_rise_stb,
    output logic       o_fall_stb,
    output logic [5:0] o_half
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [5:0]    r_half;
    logic          r_sclk;

    assign o_half_end = i_en && (r_cnt == CNT_MAX);
    // Odd halves are sclk-low; their end precedes a rising edge.
    assign o_rise_stb = o_half_end && r_half[0];
    assign o_fall_stb = o_half_end && !r_half[0] && (r_half != 6'd0);
    assign o_half     = r_half;
    assign o_sclk     = r_sclk;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_half <= '0;
            r_sclk <= 1'b1;
        end else if (!i_en_next) begin
            r_cnt  <= '0;
            r_half <= '0;
            r_sclk <= 1'b1;
        end else if (!i_en) begin
            r_cnt  <= '0;
            r_half <= '0;
        end else if (o_half_end) begin
            r_cnt  <= '0;
            r_half <= r_half + 6'd1;
            r_sclk <= r_half[0];
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ad79x8_scan_ctrl.sv
// SPI scan master for AD7908/AD7918/AD7928: power-up dummy frames, channel range scan, tagged results.
// Define ADC_ADDR_CHECK_EN to add the sticky addr_err output and returned-address checking.
module ad79x8_scan_ctrl
    import ad79x8_pkg::*;
#(
    parameter int DIGITS  = 8,
    parameter int CLK_DIV = 2,
    parameter int QUIET   = 2
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cont,
    input  logic [2:0]        ch_last,
    input  logic [1:0]        PM,
    input  logic              range,
    input  logic              coding,
    input  logic              in_slave,
    output logic              out_slave,
    output logic              cs,
    output logic              sclk,
    output logic              busy,
    output logic              out_valid,
    output logic [DIGITS-1:0] out,
    output logic [2:0]        out_ch
`ifdef ADC_ADDR_CHECK_EN
    ,
    output logic              addr_err
`endif
);

    localparam int QW = (QUIET > 1) ? $clog2(QUIET) : 1;
    localparam logic [QW-1:0] QUIET_MAX = QW'(QUIET - 1);

    state_t                r_state, w_next_state;
    logic                  r_dummy_pend;
    logic [1:0]            r_dummy_left, w_dummy_next;
    logic [3:0]            r_k, w_k_next;
    logic [2:0]            r_ch_last, w_ch_last_next, w_ch_addr;
    logic [FRAME_BITS-1:0] r_tx, w_word, w_rx_word;
    logic [FRAME_BITS-2:0] r_rx;
    logic [QW-1:0]         r_quiet;
    logic                  r_cs, r_out_slave, r_busy, r_valid;
    logic [DIGITS-1:0]     r_out;
    logic [2:0]            r_out_ch;

    logic       w_sclk, w_half_end, w_rise_stb, w_fall_stb;
    logic [5:0] w_half;
    logic       w_en, w_en_next, w_shift_done, w_hold_end, w_scan_last;
    logic       w_scan_start, w_frame_adv, w_load, w_result_done;
    logic       w_unused_rx;

    assign w_en      = (r_state == SETUP) || (r_state == SHIFT);
    assign w_en_next = (w_next_state == SETUP) || (w_next_state == SHIFT);

    ad79x8_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .reset      (reset),
        .i_en       (w_en),
        .i_en_next  (w_en_next),
        .o_sclk     (w_sclk),
        .o_half_end (w_half_end),
        .o_rise_stb (w_rise_stb),
        .o_fall_stb (w_fall_stb),
        .o_half     (w_half)
    );

    assign w_shift_done = (r_state == SHIFT) && w_half_end && (w_half == 6'(FRAME_HALVES));
    assign w_hold_end   = (r_state == HOLD) && (r_quiet == QUIET_MAX);
    assign w_scan_last  = (r_dummy_left == 2'd0) && (r_k == ({1'b0, r_ch_last} + 4'd1));
    assign w_scan_start = ((r_state == IDLE) && start) || (w_hold_end && w_scan_last && cont);
    assign w_frame_adv  = w_hold_end && !w_scan_last;
    assign w_load       = w_scan_start || w_frame_adv;

    // The ADC answers with the previous frame's conversion, so frame 0 of a scan carries no result.
    assign w_result_done = w_shift_done && (r_dummy_left == 2'd0) && (r_k != 4'd0);
    assign w_rx_word     = {r_rx, in_slave};
    assign w_unused_rx   = ^w_rx_word;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start)        w_next_state = SETUP;
            SETUP:   if (w_half_end)   w_next_state = SHIFT;
            SHIFT:   if (w_shift_done) w_next_state = HOLD;
            HOLD:    if (w_hold_end)   w_next_state = (w_scan_last && !cont) ? IDLE : SETUP;
            default:                   w_next_state = IDLE;
        endcase
    end

    // Parameters of the frame about to begin, and its control word.
    always_comb begin
        w_k_next       = r_k;
        w_dummy_next   = r_dummy_left;
        w_ch_last_next = r_ch_last;
        if (w_scan_start) begin
            w_k_next       = 4'd0;
            w_dummy_next   = r_dummy_pend ? 2'd2 : 2'd0;
            w_ch_last_next = ch_last;
        end else if (w_frame_adv) begin
            if (r_dummy_left != 2'd0) w_dummy_next = r_dummy_left - 2'd1;
            else                      w_k_next     = r_k + 4'd1;
        end
        w_ch_addr = (w_k_next > {1'b0, w_ch_last_next}) ? w_ch_last_next : w_k_next[2:0];
        w_word    = (w_dummy_next != 2'd0) ? '1 : build_ctrl(w_ch_addr, PM, range, coding);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dummy_pend <= 1'b1;
            r_dummy_left <= '0;
            r_k          <= '0;
            r_ch_last    <= '0;
            r_tx         <= '0;
            r_rx         <= '0;
            r_quiet      <= '0;
            r_cs         <= 1'b1;
            r_out_slave  <= 1'b0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_out        <= '0;
            r_out_ch     <= '0;
        end else begin
            r_k          <= w_k_next;
            r_dummy_left <= w_dummy_next;
            r_ch_last    <= w_ch_last_next;
            if (w_scan_start) r_dummy_pend <= 1'b0;

            if (w_load) begin
                r_tx        <= w_word;
                r_out_slave <= w_word[FRAME_BITS-1];
            end else if ((r_state == SHIFT) && w_rise_stb) begin
                r_out_slave <= r_tx[FRAME_BITS-2];
                r_tx        <= {r_tx[FRAME_BITS-2:0], 1'b0};
            end

            if ((r_state == SHIFT) && w_fall_stb) r_rx <= w_rx_word[FRAME_BITS-2:0];

            r_quiet <= ((r_state == HOLD) && !w_hold_end) ? r_quiet + 1'b1 : '0;
            r_cs    <= !w_en_next;
            r_busy  <= (w_next_state != IDLE);
            r_valid <= w_result_done;
            if (w_result_done) begin
                r_out    <= w_rx_word[DOUT_DATA_MSB -: DIGITS];
                r_out_ch <= w_rx_word[DOUT_ADD_LSB +: 3];
            end
        end
    end

`ifdef ADC_ADDR_CHECK_EN
    logic       r_addr_err;
    logic [2:0] w_exp_ch;

    assign w_exp_ch = r_k[2:0] - 3'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_err <= 1'b0;
        end else if (w_result_done &&
                     (w_rx_word[FRAME_BITS-1] || (w_rx_word[DOUT_ADD_LSB +: 3] != w_exp_ch))) begin
            r_addr_err <= 1'b1;
        end
    end

    assign addr_err = r_addr_err;
`endif

    assign cs        = r_cs;
    assign sclk      = w_sclk;
    assign out_slave = r_out_slave;
    assign busy      = r_busy;
    assign out_valid = r_valid;
    assign out       = r_out;
    assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_ad79x8_scan_ctrl.sv
// Directed bench for ad79x8_scan_ctrl with a behavioural AD79x8 model on the SPI pins.
`timescale 1ns/1ps
module tb_ad79x8_scan_ctrl;

    localparam int DIGITS    = 10;
    localparam int CLK_DIV   = 2;
    localparam int QUIET     = 2;
    localparam int FRAME_CYC = 33 * CLK_DIV + QUIET;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic       cont     = 1'b0;
    logic [2:0] ch_last  = 3'd0;
    logic [1:0] pm_in    = 2'd0;
    logic       rng_in   = 1'b0;
    logic       cod_in   = 1'b0;
    logic       in_slave = 1'b0;

    wire              out_slave, cs, sclk, busy, out_valid;
    wire [DIGITS-1:0] dout;
    wire [2:0]        out_ch;
`ifdef ADC_ADDR_CHECK_EN
    wire              addr_err;
`endif

    ad79x8_scan_ctrl #(
        .DIGITS  (DIGITS),
        .CLK_DIV (CLK_DIV),
        .QUIET   (QUIET)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cont      (cont),
        .ch_last   (ch_last),
        .PM        (pm_in),
        .range     (rng_in),
        .coding    (cod_in),
        .in_slave  (in_slave),
        .out_slave (out_slave),
        .cs        (cs),
        .sclk      (sclk),
        .busy      (busy),
        .out_valid (out_valid),
        .out       (dout),
        .out_ch    (out_ch)
`ifdef ADC_ADDR_CHECK_EN
        ,
        .addr_err  (addr_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    // ADC model: answers each frame with the previous frame's ADD and that channel's sample.
    logic [11:0] data_tab [8] = '{12'hABC, 12'h123, 12'h456, 12'h789,
                                  12'hFED, 12'h0F0, 12'h5A5, 12'h3C3};
    logic [15:0] m_resp   = '0;
    logic [15:0] m_din    = '0;
    int          m_j      = 0;
    logic [2:0]  m_prev   = 3'd0;
    logic        force_en = 1'b0;

    logic [15:0]       din_q[$];
    int                fr_t_q[$];
    logic [DIGITS-1:0] res_out_q[$];
    logic [2:0]        res_ch_q[$];
    int                busy_cycles = 0;

    always @(negedge cs) begin
        m_j    = 0;
        m_din  = '0;
        m_resp = {1'b0, ((force_en && m_prev == 3'd2) ? 3'd5 : m_prev), data_tab[m_prev]};
        fr_t_q.push_back(cyc);
    end

    always @(negedge sclk) begin
        if (!cs && m_j < 16) begin
            in_slave = m_resp[15 - m_j];
            m_din    = {m_din[14:0], out_slave};
            m_j++;
        end
    end

    always @(posedge cs) begin
        if (m_j == 16) begin
            din_q.push_back(m_din);
            m_prev = m_din[12:10];
        end
    end

    always @(negedge clk) begin
        if (busy) busy_cycles++;
        if (out_valid) begin
            res_out_q.push_back(dout);
            res_ch_q.push_back(out_ch);
            $display("result ch=%0d out=%h cycle=%0d", out_ch, dout, cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_ctrl(input int add, input logic [1:0] pm,
                                             input logic rng, input logic cod);
        logic [2:0] a;
        a = add[2:0];
        return {1'b1, 1'b0, 1'b0, a, pm, 1'b0, 1'b0, rng, cod, 4'b0000};
    endfunction

    task automatic clear_logs();
        din_q.delete();
        fr_t_q.delete();
        res_out_q.delete();
        res_ch_q.delete();
        busy_cycles = 0;
    endtask

    task automatic wait_idle(input string name);
        int b;
        b = 0;
        while (busy && b < 3000) begin
            @(negedge clk);
            b++;
        end
        if (busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: busy still high after %0d cycles", name, b);
        end
    endtask

    // One scan with full frame/result checking; extra_at>0 pulses start again mid-scan.
    task automatic run_scan(input string name, input logic [2:0] chl, input logic [1:0] pm,
                            input logic rng, input logic cod, input int exp_dummy,
                            input int exp_busy, input int extra_at);
        int b, nfr, add;
        clear_logs();
        @(negedge clk);
        ch_last = chl; pm_in = pm; rng_in = rng; cod_in = cod; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b = 0;
        while (busy && b < 3000) begin
            @(negedge clk);
            b++;
            if (extra_at > 0 && b == extra_at) begin
                start = 1'b1; ch_last = 3'd7;
            end else begin
                start = 1'b0;
            end
        end
        if (busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: busy high after %0d cycles", name, b);
        end
        nfr = exp_dummy + int'(chl) + 2;
        $display("scan %s: ch_last=%0d frames=%0d results=%0d busy=%0d",
                 name, chl, din_q.size(), res_out_q.size(), busy_cycles);
        chk({name, " frames"}, din_q.size(), nfr);
        for (int i = 0; i < din_q.size() && i < nfr; i++) begin
            if (i < exp_dummy) begin
                chk($sformatf("%s dummy%0d", name, i), din_q[i], 16'hFFFF);
            end else begin
                add = (i - exp_dummy > int'(chl)) ? int'(chl) : i - exp_dummy;
                chk($sformatf("%s din%0d", name, i), din_q[i], exp_ctrl(add, pm, rng, cod));
            end
        end
        chk({name, " results"}, res_out_q.size(), int'(chl) + 1);
        for (int i = 0; i < res_out_q.size() && i <= int'(chl); i++) begin
            chk($sformatf("%s out_ch%0d", name, i), res_ch_q[i], i);
            chk($sformatf("%s out%0d", name, i), res_out_q[i], data_tab[i][11:2]);
        end
        chk({name, " busy_cycles"}, busy_cycles, exp_busy);
    endtask

    typedef struct {
        logic [2:0] chl;
        logic [1:0] pm;
        logic       rng;
        logic       cod;
        int         dummy;
        int         busy_cyc;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int b;
        vecs[0] = '{3'd3, 2'b11, 1'b1, 1'b1, 2, 7 * FRAME_CYC};
        vecs[1] = '{3'd0, 2'b01, 1'b0, 1'b1, 0, 2 * FRAME_CYC};
        vecs[2] = '{3'd7, 2'b11, 1'b0, 1'b0, 0, 9 * FRAME_CYC};
        vecs[3] = '{3'd5, 2'b10, 1'b1, 1'b0, 0, 7 * FRAME_CYC};

        repeat (3) @(negedge clk);
        chk("rst cs", cs, 1'b1);
        chk("rst sclk", sclk, 1'b1);
        chk("rst out_slave", out_slave, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst out", dout, '0);
        chk("rst out_ch", out_ch, 3'd0);
`ifdef ADC_ADDR_CHECK_EN
        chk("rst addr_err", addr_err, 1'b0);
`endif
        reset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            run_scan($sformatf("vec%0d", v), vecs[v].chl, vecs[v].pm, vecs[v].rng,
                     vecs[v].cod, vecs[v].dummy, vecs[v].busy_cyc, 0);
            if (v == 0 && res_out_q.size() > 0) chk("resolution 0xABC", res_out_q[0], 10'h2AF);
        end

        // Continuous mode: two back-to-back single-channel scans.
        clear_logs();
        @(negedge clk);
        ch_last = 3'd0; pm_in = 2'b00; rng_in = 1'b0; cod_in = 1'b1; cont = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b = 0;
        while (fr_t_q.size() < 4 && b < 2000) begin
            @(negedge clk);
            b++;
        end
        cont = 1'b0;
        wait_idle("cont");
        $display("scan cont: frames=%0d results=%0d busy=%0d", din_q.size(), res_out_q.size(), busy_cycles);
        chk("cont frames", din_q.size(), 4);
        for (int i = 0; i < din_q.size(); i++)
            chk($sformatf("cont din%0d", i), din_q[i], exp_ctrl(0, 2'b00, 1'b0, 1'b1));
        for (int i = 1; i < fr_t_q.size(); i++)
            chk($sformatf("cont pitch%0d", i), fr_t_q[i] - fr_t_q[i-1], FRAME_CYC);
        chk("cont results", res_out_q.size(), 2);
        for (int i = 0; i < res_ch_q.size(); i++)
            chk($sformatf("cont out_ch%0d", i), res_ch_q[i], 3'd0);
        chk("cont busy_cycles", busy_cycles, 4 * FRAME_CYC);

        // Start while busy is dropped.
        run_scan("busy_start", 3'd2, 2'b11, 1'b0, 1'b1, 0, 4 * FRAME_CYC, 100);

        // Reset during SHIFT bit 7 of the first frame re-arms the dummy frames.
        clear_logs();
        @(negedge clk);
        ch_last = 3'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b = 0;
        while (!(cs == 1'b0 && m_j == 8) && b < 2000) begin
            @(negedge clk);
            b++;
        end
        chk("midrst reached bit7", m_j, 8);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst cs", cs, 1'b1);
        chk("midrst sclk", sclk, 1'b1);
        chk("midrst busy", busy, 1'b0);
        reset = 1'b0;
        run_scan("after_rst", 3'd1, 2'b01, 1'b1, 1'b0, 2, 5 * FRAME_CYC, 0);

`ifdef ADC_ADDR_CHECK_EN
        chk("addr_err clear", addr_err, 1'b0);
        clear_logs();
        force_en = 1'b1;
        @(negedge clk);
        ch_last = 3'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("addr");
        force_en = 1'b0;
        chk("addr results", res_out_q.size(), 4);
        if (res_ch_q.size() > 2) chk("addr out_ch2", res_ch_q[2], 3'd5);
        chk("addr_err set", addr_err, 1'b1);
        run_scan("addr_clean", 3'd1, 2'b11, 1'b0, 1'b1, 0, 3 * FRAME_CYC, 0);
        chk("addr_err sticky", addr_err, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("addr_err reset", addr_err, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
